sprf_model: RTL and testbench
=============================

// Module: sprf_model
// PURPOSE
//  Behavioural model of a single-port register-file SRAM macro (S40 SPRF style).
//  One synchronous port: per-cycle read or bit-masked write, registered output.
//  Serves as the functional body behind the NPU macro names S40SPRF_NPU_1024X19,
//  rfsp512x128 and S40SPRF_NPU_128X128, which rfsp_wrapper selects by WORDSWD/BITS.
// PARAMETERS
//  WORDSWD  10             address width; depth WORDS = 2**WORDSWD
//  BITS     19             data word width
// PORTS
//  CLK    in   1        clock; all storage updates on the rising edge
//  RSTN   in   1        asynchronous active-low reset (affects Q only)
//  CEN    in   1        chip enable, active low
//  GWEN   in   1        global write enable, active low (0=write, 1=read)
//  WEN    in   BITS     per-bit write enable, active low
//  A      in   WORDSWD  word address
//  D      in   BITS     write data
//  EMA    in   3        extra margin adjust; accepted, no functional effect
//  EMAW   in   2        write margin adjust; accepted, no functional effect
//  RET1N  in   1        retention control, active low (0=retention mode)
//  Q      out  BITS     registered read data
// BEHAVIOUR
//  - Storage: WORDS x BITS array; NOT cleared by RSTN; contents undefined until written.
//  - RSTN=0 (async): Q <= 0 immediately; held 0 while RSTN=0; array untouched.
//  - Rising CLK with RSTN=1, RET1N=1, CEN=0:
//    * GWEN=1 (read): Q <= mem[A]; 1-cycle latency, valid after the edge.
//    * GWEN=0 (write): for each bit i with WEN[i]=0, mem[A][i] <= D[i];
//      bits with WEN[i]=1 keep old value. Q holds its previous value.
//    * GWEN=0 with WEN all 1s: no array change, Q holds.
//  - CEN=1: no access; array and Q hold.
//  - RET1N=0: all accesses ignored regardless of CEN; array retained; Q holds.
//    Normal operation resumes on the first edge after RET1N returns to 1.
//  - Read-after-write same address: next-cycle read returns newly written data.
//  - A is always in range (depth is a power of two); no wrap logic needed.
//  - EMA/EMAW: ignored functionally; any value legal.
//  - Simulation aid: X/Z on CEN, GWEN or RET1N at a clock edge drives Q to all-X
//    (array unchanged); synthesis ignores this check.
// STRUCTURE
//  - Package sprf_pkg: constants for the three NPU configs
//    (1024x19: WORDSWD=10/BITS=19; 512x128: 9/128; 128x128: 7/128) and an
//    access-type enum {IDLE, READ, WRITE, RETAIN} used for decode.
//  - Sub-module: macro shells S40SPRF_NPU_1024X19, rfsp512x128,
//    S40SPRF_NPU_128X128, each a thin instance of sprf_model with fixed params
//    and identical port list (RSTN tied from top-level reset).
//  - Core: access decode (comb), array write with bit mask, Q output register.
// TESTING
//  1 Reset: RSTN=0 with Q previously 19'h5A5A5 -> Q=0 asynchronously, before next CLK.
//  2 Write/read 1024x19: write A=10'h3FF D=19'h7FFFF WEN=0; read A=3FF -> Q=19'h7FFFF
//    one cycle later; Q unchanged during the write cycle.
//  3 Bit mask 128x128: write A=0 D=all-1 WEN=0; then D=0 with WEN=128'hFFFF...0000
//    (low 16 bits enabled) -> read A=0 gives 128'hFFFF...0000.
//  4 Disabled/retention 512x128: write A=9'h1F0 = 128'hDEAD..BEEF; then CEN=1 write
//    of 0, and RET1N=0 with CEN=0 write of 0 -> read returns 128'hDEAD..BEEF.
//  5 Back-to-back: write A=5, read A=5 next cycle -> Q=new data; EMA=3'b111 and
//    EMAW=2'b11 give identical results.
//  6 Address sweep per config: write mem[i]=i across all WORDS, read back all -> Q=i,
//    confirms no aliasing at A=0 and A=WORDS-1.

Source files
------------

// File: rtl/sprf_pkg.sv
// Shared definitions for the single-port register-file model: the three NPU
// macro geometries and the per-cycle access decode type.
package sprf_pkg;

  // Geometry of the S40SPRF_NPU_1024X19 macro
  localparam int SPRF_1024X19_WORDSWD = 10;
  localparam int SPRF_1024X19_BITS    = 19;

  // Geometry of the rfsp512x128 macro
  localparam int SPRF_512X128_WORDSWD = 9;
  localparam int SPRF_512X128_BITS    = 128;

  // Geometry of the S40SPRF_NPU_128X128 macro
  localparam int SPRF_128X128_WORDSWD = 7;
  localparam int SPRF_128X128_BITS    = 128;

  // What the port does on the coming clock edge
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    RETAIN = 2'd3
  } access_t;

endpackage

// File: rtl/sprf_model_shells.sv
// Named macro shells: each is the generic model pinned to one NPU geometry,
// keeping the macro port list so the wrapper can select them by name.
module S40SPRF_NPU_1024X19
  import sprf_pkg::*;
(
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic                            CEN,
  input  logic                            GWEN,
  input  logic [SPRF_1024X19_BITS-1:0]    WEN,
  input  logic [SPRF_1024X19_WORDSWD-1:0] A,
  input  logic [SPRF_1024X19_BITS-1:0]    D,
  input  logic [2:0]                      EMA,
  input  logic [1:0]                      EMAW,
  input  logic                            RET1N,
  output logic [SPRF_1024X19_BITS-1:0]    Q
);
  sprf_model #(.WORDSWD(SPRF_1024X19_WORDSWD), .BITS(SPRF_1024X19_BITS)) u_core (
    .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D),
    .EMA(EMA), .EMAW(EMAW), .RET1N(RET1N), .Q(Q)
  );
endmodule

module rfsp512x128
  import sprf_pkg::*;
(
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic                            CEN,
  input  logic                            GWEN,
  input  logic [SPRF_512X128_BITS-1:0]    WEN,
  input  logic [SPRF_512X128_WORDSWD-1:0] A,
  input  logic [SPRF_512X128_BITS-1:0]    D,
  input  logic [2:0]                      EMA,
  input  logic [1:0]                      EMAW,
  input  logic                            RET1N,
  output logic [SPRF_512X128_BITS-1:0]    Q
);
  sprf_model #(.WORDSWD(SPRF_512X128_WORDSWD), .BITS(SPRF_512X128_BITS)) u_core (
    .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D),
    .EMA(EMA), .EMAW(EMAW), .RET1N(RET1N), .Q(Q)
  );
endmodule

module S40SPRF_NPU_128X128
  import sprf_pkg::*;
(
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic                            CEN,
  input  logic                            GWEN,
  input  logic [SPRF_128X128_BITS-1:0]    WEN,
  input  logic [SPRF_128X128_WORDSWD-1:0] A,
  input  logic [SPRF_128X128_BITS-1:0]    D,
  input  logic [2:0]                      EMA,
  input  logic [1:0]                      EMAW,
  input  logic                            RET1N,
  output logic [SPRF_128X128_BITS-1:0]    Q
);
  sprf_model #(.WORDSWD(SPRF_128X128_WORDSWD), .BITS(SPRF_128X128_BITS)) u_core (
    .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D),
    .EMA(EMA), .EMAW(EMAW), .RET1N(RET1N), .Q(Q)
  );
endmodule

// File: rtl/sprf_model.sv
// Behavioural single-port register file: one synchronous port doing either a
// read or a bit-masked write per cycle, with a registered read-data output.
// The array is deliberately not reset; only Q is cleared by RSTN.
module sprf_model
  import sprf_pkg::*;
#(
  parameter int WORDSWD = 10,
  parameter int BITS    = 19
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               CEN,
  input  logic               GWEN,
  input  logic [BITS-1:0]    WEN,
  input  logic [WORDSWD-1:0] A,
  input  logic [BITS-1:0]    D,
  input  logic [2:0]         EMA,
  input  logic [1:0]         EMAW,
  input  logic               RET1N,
  output logic [BITS-1:0]    Q
);

  localparam int WORDS = 2 ** WORDSWD;

  logic [BITS-1:0] mem_r [WORDS];
  logic [BITS-1:0] q_r;
  access_t         access_s;
  logic            ctrl_unknown_s;
  logic            unused_s;

  // Margin-adjust pins have no functional effect in this model
  assign unused_s = ^{EMA, EMAW};

  // Control pins carrying X/Z poison the read data in 4-state simulation
  assign ctrl_unknown_s = $isunknown({CEN, GWEN, RET1N});

  // Decode the access for this edge; retention overrides chip enable
  always_comb begin
    access_s = IDLE;
    if (!RET1N) begin
      access_s = RETAIN;
    end else if (!CEN) begin
      if (GWEN) begin
        access_s = READ;
      end else begin
        access_s = WRITE;
      end
    end else begin
      access_s = IDLE;
    end
  end

  // Bit-masked array write: bits with WEN low take D, others keep old value
  always_ff @(posedge CLK) begin
    if (access_s == WRITE && !ctrl_unknown_s) begin
      mem_r[A] <= (mem_r[A] & WEN) | (D & ~WEN);
    end
  end

  // Read-data register: cleared asynchronously, loaded only on a read
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q_r <= {BITS{1'b0}};
    end else if (ctrl_unknown_s) begin
      q_r <= {BITS{1'bx}};
    end else begin
      case (access_s)
        READ:    q_r <= mem_r[A];
        WRITE:   q_r <= q_r;
        RETAIN:  q_r <= q_r;
        IDLE:    q_r <= q_r;
        default: q_r <= q_r;
      endcase
    end
  end

  assign Q = q_r;

endmodule

// File: tb/tb_sprf_model.sv
// Directed self-checking bench for the single-port register-file model,
// exercising the 1024x19 geometry directly and all three macro shells.
module tb_sprf_model;
  import sprf_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cen19, cen512, cen128;
  logic         gwen;
  logic         ret1n;
  logic [127:0] wen;
  logic [9:0]   a;
  logic [127:0] d;
  logic [2:0]   ema;
  logic [1:0]   emaw;
  logic [18:0]  q19, q19s;
  logic [127:0] q512, q128;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sprf_model #(.WORDSWD(10), .BITS(19)) dut (
    .CLK(clk), .RSTN(rst_n), .CEN(cen19), .GWEN(gwen), .WEN(wen[18:0]),
    .A(a), .D(d[18:0]), .EMA(ema), .EMAW(emaw), .RET1N(ret1n), .Q(q19)
  );

  S40SPRF_NPU_1024X19 u_m19 (
    .CLK(clk), .RSTN(rst_n), .CEN(cen19), .GWEN(gwen), .WEN(wen[18:0]),
    .A(a), .D(d[18:0]), .EMA(ema), .EMAW(emaw), .RET1N(ret1n), .Q(q19s)
  );

  rfsp512x128 u_m512 (
    .CLK(clk), .RSTN(rst_n), .CEN(cen512), .GWEN(gwen), .WEN(wen),
    .A(a[8:0]), .D(d), .EMA(ema), .EMAW(emaw), .RET1N(ret1n), .Q(q512)
  );

  S40SPRF_NPU_128X128 u_m128 (
    .CLK(clk), .RSTN(rst_n), .CEN(cen128), .GWEN(gwen), .WEN(wen),
    .A(a[6:0]), .D(d), .EMA(ema), .EMAW(emaw), .RET1N(ret1n), .Q(q128)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One access on the selected macro (0=1024x19, 1=512x128, 2=128x128)
  task automatic acc(input int sel, input logic wr, input logic [9:0] addr,
                     input logic [127:0] data, input logic [127:0] wmask);
    a      = addr;
    d      = data;
    wen    = wmask;
    gwen   = ~wr;
    cen19  = (sel != 0);
    cen512 = (sel != 1);
    cen128 = (sel != 2);
    cyc();
    cen19  = 1'b1;
    cen512 = 1'b1;
    cen128 = 1'b1;
    gwen   = 1'b1;
    wen    = {128{1'b1}};
  endtask

  initial begin
    rst_n  = 1'b0;
    cen19  = 1'b1;
    cen512 = 1'b1;
    cen128 = 1'b1;
    gwen   = 1'b1;
    ret1n  = 1'b1;
    wen    = {128{1'b1}};
    a      = 10'd0;
    d      = 128'd0;
    ema    = 3'd0;
    emaw   = 2'd0;
    cyc();
    cyc();
    check_eq("rst_q19",  {109'd0, q19},  128'd0);
    check_eq("rst_q512", q512, 128'd0);
    check_eq("rst_q128", q128, 128'd0);
    rst_n = 1'b1;
    cyc();

    // Async reset clears Q before any clock edge
    acc(0, 1'b1, 10'd1, 128'h5A5A5, 128'd0);
    acc(0, 1'b0, 10'd1, 128'd0, {128{1'b1}});
    check_eq("pre_rst_q19",  {109'd0, q19},  128'h5A5A5);
    check_eq("pre_rst_q19s", {109'd0, q19s}, 128'h5A5A5);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_q19",  {109'd0, q19},  128'd0);
    check_eq("async_rst_q19s", {109'd0, q19s}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Top-address write/read on 1024x19; Q holds during the write
    acc(0, 1'b1, 10'h3FF, 128'h7FFFF, 128'd0);
    check_eq("wr_hold_q19", {109'd0, q19}, 128'd0);
    acc(0, 1'b0, 10'h3FF, 128'd0, {128{1'b1}});
    check_eq("rd_3ff_q19",  {109'd0, q19},  128'h7FFFF);
    check_eq("rd_3ff_q19s", {109'd0, q19s}, 128'h7FFFF);

    // Bit-masked write on 128x128: only the low 16 bits are cleared
    acc(2, 1'b1, 10'd0, {128{1'b1}}, 128'd0);
    acc(2, 1'b1, 10'd0, 128'd0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000);
    acc(2, 1'b0, 10'd0, 128'd0, {128{1'b1}});
    check_eq("mask_q128", q128, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000);

    // Disabled and retention accesses leave 512x128 untouched
    acc(1, 1'b1, 10'h1F0, 128'hDEAD_0000_1111_2222_3333_4444_0000_BEEF, 128'd0);
    acc(1, 1'b0, 10'h1F0, 128'd0, {128{1'b1}});
    check_eq("rd_1f0_q512", q512, 128'hDEAD_0000_1111_2222_3333_4444_0000_BEEF);
    a = 10'h1F0; d = 128'd0; wen = 128'd0; gwen = 1'b0; cen512 = 1'b1;
    cyc();
    gwen = 1'b1; wen = {128{1'b1}};
    ret1n = 1'b0;
    acc(1, 1'b1, 10'h1F0, 128'd0, 128'd0);
    acc(1, 1'b0, 10'h010, 128'd0, {128{1'b1}});
    check_eq("ret_hold_q512", q512, 128'hDEAD_0000_1111_2222_3333_4444_0000_BEEF);
    ret1n = 1'b1;
    acc(1, 1'b0, 10'h010, 128'd0, {128{1'b1}});
    acc(1, 1'b0, 10'h1F0, 128'd0, {128{1'b1}});
    check_eq("ret_keep_q512", q512, 128'hDEAD_0000_1111_2222_3333_4444_0000_BEEF);

    // Back-to-back write then read, then with maximum margin settings
    acc(0, 1'b1, 10'd5, 128'h12345, 128'd0);
    acc(0, 1'b0, 10'd5, 128'd0, {128{1'b1}});
    check_eq("b2b_q19", {109'd0, q19}, 128'h12345);
    ema = 3'b111; emaw = 2'b11;
    acc(0, 1'b1, 10'd5, 128'h6789A, 128'd0);
    acc(0, 1'b0, 10'd5, 128'd0, {128{1'b1}});
    check_eq("b2b_ema_q19", {109'd0, q19}, 128'h6789A);
    acc(0, 1'b1, 10'd5, 128'd0, {128{1'b1}});
    check_eq("nomask_hold_q19", {109'd0, q19}, 128'h6789A);
    acc(0, 1'b0, 10'd5, 128'd0, {128{1'b1}});
    check_eq("nomask_keep_q19", {109'd0, q19}, 128'h6789A);
    ema = 3'd0; emaw = 2'd0;

    // Address sweep on every geometry: mem[i] = i, then read back
    wen  = 128'd0;
    gwen = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      a      = i[9:0];
      d      = 128'(i);
      cen19  = 1'b0;
      cen512 = (i < 512) ? 1'b0 : 1'b1;
      cen128 = (i < 128) ? 1'b0 : 1'b1;
      cyc();
    end
    gwen = 1'b1;
    wen  = {128{1'b1}};
    for (int i = 0; i < 1024; i++) begin
      a      = i[9:0];
      cen19  = 1'b0;
      cen512 = (i < 512) ? 1'b0 : 1'b1;
      cen128 = (i < 128) ? 1'b0 : 1'b1;
      cyc();
      check_eq("sweep_q19", {109'd0, q19}, 128'(i));
      if (i < 512) check_eq("sweep_q512", q512, 128'(i));
      if (i < 128) check_eq("sweep_q128", q128, 128'(i));
    end
    cen19 = 1'b1; cen512 = 1'b1; cen128 = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
